// File: rtl/arbitro_xor_pkg.sv
// arbitro_xor_pkg
// Shared definitions for the two-requester XOR arbiter:
//   - state_t       : arbiter FSM encoding (IDLE=0, BUSY=1)
//   - REQ0 / REQ1   : requester index constants
//   - DEFAULT_WIDTH : default operand/result width
package arbitro_xor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage : arbitro_xor_pkg

// File: rtl/porta_xor_nbits.sv
// porta_xor_nbits
// Purely combinational WIDTH-bit bitwise XOR, no carry, no width growth.
// Ports:
//   a, b : WIDTH-bit operands
//   y    : WIDTH-bit result, y = a ^ b
module porta_xor_nbits #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule : porta_xor_nbits

// File: rtl/arbitro_xor.sv
// arbitro_xor
// Round-robin arbiter and sequencer placing two requesters onto one shared
// XOR unit. A granted operand pair is XORed, registered and held on the
// result port until the consumer accepts it; only then is the next pair
// accepted, so one result at most every two cycles.
// Ports:
//   clk, rst                      : rising-edge clock, synchronous active-high reset
//   req0_valid/a/b, req0_ready    : requester 0 handshake and operands
//   req1_valid/a/b, req1_ready    : requester 1 handshake and operands
//   res_valid, res_ready          : result handshake
//   res_data                      : registered a ^ b
//   res_id                        : requester that produced res_data
//   res_parity                    : reduction XOR of res_data, only when
//                                   ARBITRO_XOR_PARITY_EN is defined
module arbitro_xor
  import arbitro_xor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
`ifdef ARBITRO_XOR_PARITY_EN
  ,
  output logic             res_parity
`endif
);

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant_any;
  logic             grant_sel;
  logic             transfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] xor_y;

  // Tie goes to whoever did not win last time; otherwise the lone requester.
  // Readys are gated by rst so nothing is handed out while resetting.
  always_comb begin
    grant_any  = 1'b0;
    grant_sel  = REQ0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_next = state;

    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else if (req1_valid) begin
      grant_sel = REQ1;
    end

    if (state == IDLE && !rst && (req0_valid || req1_valid)) begin
      grant_any = 1'b1;
    end

    req0_ready = grant_any && (grant_sel == REQ0);
    req1_ready = grant_any && (grant_sel == REQ1);

    case (state)
      IDLE:    if (grant_any) state_next = BUSY;
      BUSY:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign transfer = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // The shared XOR unit only ever sees the granted requester's operands.
  assign op_a = (grant_sel == REQ1) ? req1_a : req0_a;
  assign op_b = (grant_sel == REQ1) ? req1_b : req0_b;

  porta_xor_nbits #(
    .WIDTH(WIDTH)
  ) u_porta_xor (
    .a(op_a),
    .b(op_b),
    .y(xor_y)
  );

  // last_grant resets to REQ1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ1;
      res_data   <= '0;
      res_id     <= REQ0;
`ifdef ARBITRO_XOR_PARITY_EN
      res_parity <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (transfer) begin
        res_data   <= xor_y;
        res_id     <= grant_sel;
        last_grant <= grant_sel;
`ifdef ARBITRO_XOR_PARITY_EN
        res_parity <= ^xor_y;
`endif
      end
    end
  end

  // A result is held exactly while the FSM sits in BUSY.
  assign res_valid = (state == BUSY);

endmodule : arbitro_xor

// File: tb/tb_arbitro_xor.sv
// tb_arbitro_xor
// Table-driven bench for arbitro_xor: each record is one clock cycle of
// inputs plus the outputs expected during that cycle. A hand-written
// sequence afterwards checks sustained round-robin throughput after reset.
// Build with ARBITRO_XOR_PARITY_EN defined to also cover res_parity.
module tb_arbitro_xor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
`ifdef ARBITRO_XOR_PARITY_EN
  logic             res_parity;
`endif

  arbitro_xor #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef ARBITRO_XOR_PARITY_EN
    ,
    .res_parity(res_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rr;
    logic       e_r0;
    logic       e_r1;
    logic       e_rv;
    logic [7:0] e_data;
    logic       e_id;
  } vec_t;

  vec_t vecs[$];
  int   vec_count;
  int   miss_count;

  task automatic add_vec(input logic r, input logic v0, input logic [7:0] a0,
                         input logic [7:0] b0, input logic v1, input logic [7:0] a1,
                         input logic [7:0] b1, input logic rr, input logic e_r0,
                         input logic e_r1, input logic e_rv, input logic [7:0] e_data,
                         input logic e_id);
    vec_t v;
    v.rst = r;   v.v0 = v0;   v.a0 = a0;     v.b0 = b0;
    v.v1 = v1;   v.a1 = a1;   v.b1 = b1;     v.rr = rr;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_data = e_data; v.e_id = e_id;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst        = v.rst;
    req0_valid = v.v0;
    req0_a     = v.a0;
    req0_b     = v.b0;
    req1_valid = v.v1;
    req1_a     = v.a1;
    req1_b     = v.b1;
    res_ready  = v.rr;
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [7:0] actual, input logic [7:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s @%0d: got %h, expected %h", name, idx, actual, expected);
    end
  endtask

  task automatic check_vector(input vec_t v, input int idx);
    check_output("req0_ready", idx, {7'b0, req0_ready}, {7'b0, v.e_r0});
    check_output("req1_ready", idx, {7'b0, req1_ready}, {7'b0, v.e_r1});
    check_output("res_valid",  idx, {7'b0, res_valid},  {7'b0, v.e_rv});
    check_output("res_data",   idx, res_data,           v.e_data);
    check_output("res_id",     idx, {7'b0, res_id},     {7'b0, v.e_id});
`ifdef ARBITRO_XOR_PARITY_EN
    check_output("res_parity", idx, {7'b0, res_parity}, {7'b0, ^v.e_data});
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_count  = 0;
    miss_count = 0;

    //      rst v0 a0     b0     v1 a1     b1     rr  r0 r1 rv data   id
    // Reset with both valids high.
    add_vec(1, 1, 8'hA5, 8'h0F, 1, 8'hF0, 8'h0F, 0,  0, 0, 0, 8'h00, 0);
    add_vec(1, 1, 8'hA5, 8'h0F, 1, 8'hF0, 8'h0F, 0,  0, 0, 0, 8'h00, 0);
    // Single request from requester 0.
    add_vec(0, 1, 8'hA5, 8'h0F, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00, 0);
    add_vec(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 1, 8'hAA, 0);
    // Both valid, res_ready high: alternates starting with req1 (req0 won last).
    add_vec(0, 1, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  0, 1, 0, 8'hAA, 0);
    add_vec(0, 1, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  0, 0, 1, 8'hFF, 1);
    add_vec(0, 1, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  1, 0, 0, 8'hFF, 1);
    add_vec(0, 1, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  0, 0, 1, 8'hFF, 0);
    add_vec(0, 1, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  0, 1, 0, 8'hFF, 0);
    add_vec(0, 0, 8'h00, 8'hFF, 1, 8'hF0, 8'h0F, 1,  0, 0, 1, 8'hFF, 1);
    // Backpressure: result 3C held for 5 stalled cycles.
    add_vec(0, 1, 8'h30, 8'h0C, 0, 8'h00, 8'h00, 0,  1, 0, 0, 8'hFF, 1);
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, 8'h30, 8'h0C, 1, 8'h11, 8'h22, 0,  0, 0, 1, 8'h3C, 0);
    add_vec(0, 1, 8'h30, 8'h0C, 1, 8'h11, 8'h22, 1,  0, 0, 1, 8'h3C, 0);
    add_vec(0, 1, 8'h30, 8'h0C, 1, 8'h11, 8'h22, 0,  0, 1, 0, 8'h3C, 0);
    add_vec(0, 1, 8'h30, 8'h0C, 0, 8'h00, 8'h00, 0,  0, 0, 1, 8'h33, 1);
    // Reset mid-BUSY discards the result; next tie goes to requester 0.
    add_vec(1, 1, 8'h30, 8'h0C, 1, 8'h11, 8'h22, 0,  0, 0, 1, 8'h33, 1);
    add_vec(0, 1, 8'h01, 8'h02, 1, 8'h11, 8'h22, 1,  1, 0, 0, 8'h00, 0);
    // req1 stays valid across the BUSY->IDLE edge and is granted only after it.
    add_vec(0, 0, 8'h00, 8'h00, 1, 8'h11, 8'h22, 1,  0, 0, 1, 8'h03, 0);
    add_vec(0, 0, 8'h00, 8'h00, 1, 8'h11, 8'h22, 1,  0, 1, 0, 8'h03, 0);
    add_vec(0, 1, 8'h07, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 1, 8'h33, 1);
    add_vec(0, 1, 8'h07, 8'h00, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h33, 1);
    add_vec(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 1, 8'h07, 0);
    add_vec(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h07, 0);

    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_b     = '0;
    res_ready  = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      #3;
      check_vector(vecs[i], i);
      @(posedge clk);
      #1;
    end

    // Fresh reset, then both requesters valid forever with res_ready high:
    // a result every other cycle, ids 0,1,0,1.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_a     = 8'h00;
    req0_b     = 8'hFF;
    req1_valid = 1'b1;
    req1_a     = 8'hF0;
    req1_b     = 8'h0F;
    res_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #3;
      check_output("rr_valid", 100 + k, {7'b0, res_valid}, {7'b0, 1'(k % 2)});
      if (k % 2 == 1) begin
        check_output("rr_data", 100 + k, res_data, 8'hFF);
        check_output("rr_id", 100 + k, {7'b0, res_id}, {7'b0, 1'((k / 2) % 2)});
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule : tb_arbitro_xor
